// File: rtl/fp_div.sv
// fp_div: iterative radix-2 restoring IEEE-754 divider (fp16/fp32/fp64) with RNE rounding
module grs_rounder #(
  parameter int W = 11
) (
  input  logic [W-1:0] mant,
  input  logic         g,
  input  logic         r,
  input  logic         s,
  output logic [W:0]   rounded
);
  assign rounded = {1'b0, mant} + (W+1)'(g & (r | s | mant[0]));
endmodule

module fp_div #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);
  localparam int EXP_W = WIDTH == 64 ? 11 : WIDTH == 32 ? 8 : 5;
  localparam int M = WIDTH - 1 - EXP_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EW = EXP_W + 3;
  localparam logic [EXP_W-1:0] EMAX = '1;

  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, ROUND, DONE} state_t;

  state_t state_q, state_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d, dbz_q, dbz_d, sign_q, sign_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic signed [EW-1:0] exp_q, exp_d;
  logic [M+1:0] rem_q, rem_d;
  logic [M:0] div_q, div_d;
  logic [M+2:0] q_q, q_d;
  logic [6:0] cnt_q, cnt_d;

  function automatic logic [6:0] lzc(input logic [M:0] x);
    lzc = 7'(M + 1);
    for (int i = 0; i <= M; i++) lzc = x[i] ? 7'(M - i) : lzc;
  endfunction

  logic sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [M-1:0] fa, fb;
  assign {sa, ea, fa} = a_q;
  assign {sb, eb, fb} = b_q;

  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, is_nan, special, spec_dbz, lt;
  logic [WIDTH-1:0] spec_res;
  assign a_zero = ea == '0 && fa == '0;
  assign b_zero = eb == '0 && fb == '0;
  assign a_inf = ea == EMAX && fa == '0;
  assign b_inf = eb == EMAX && fb == '0;
  assign a_nan = ea == EMAX && fa != '0;
  assign b_nan = eb == EMAX && fb != '0;
  assign is_nan = a_nan | b_nan | (a_inf & b_inf) | (a_zero & b_zero);
  assign special = is_nan | a_inf | b_inf | a_zero | b_zero;
  assign spec_dbz = !is_nan && !a_inf && b_zero;
  assign spec_res = is_nan ? {1'b0, EMAX, 1'b1, (M-1)'(0)} :
                    (a_inf | b_zero) ? {sa ^ sb, EMAX, M'(0)} : {sa ^ sb, (WIDTH-1)'(0)};

  // Denormals are normalized so both significands carry a leading one
  logic [6:0] la, lb;
  logic [M:0] ma, mb;
  logic signed [EW-1:0] xa, xb, xe;
  assign la = lzc({|ea, fa});
  assign lb = lzc({|eb, fb});
  assign ma = {|ea, fa} << la;
  assign mb = {|eb, fb} << lb;
  assign xa = (ea == '0 ? EW'(1) : EW'(ea)) - EW'(la);
  assign xb = (eb == '0 ? EW'(1) : EW'(eb)) - EW'(lb);
  assign xe = xa - xb + EW'(BIAS);
  assign lt = ma < mb;

  logic ge;
  logic [M+1:0] rs;
  assign ge = rem_q >= {1'b0, div_q};
  assign rs = ge ? rem_q - {1'b0, div_q} : rem_q;

  logic uf, lost, ovf;
  logic signed [EW-1:0] ns, fe;
  logic [EW-1:0] sh;
  logic [M+2:0] shq;
  logic [M+1:0] rnd;
  logic [M-1:0] frac;
  logic [WIDTH-1:0] rnd_res;
  assign uf = exp_q[EW-1] || exp_q == '0;
  assign ns = EW'(1) - exp_q;
  assign sh = !uf ? '0 : ns > EW'(M + 3) ? EW'(M + 3) : ns;
  assign shq = q_q >> sh;
  assign lost = (shq << sh) != q_q;

  grs_rounder #(.W(M + 1)) u_rnd (
    .mant(shq[M+2:2]),
    .g(shq[1]),
    .r(shq[0]),
    .s(lost | (|rem_q)),
    .rounded(rnd)
  );

  // A denormal rounding up into the hidden bit lands on exponent 1 naturally
  assign fe = uf ? EW'(rnd[M]) : exp_q + EW'(rnd[M+1]);
  assign frac = rnd[M+1] ? rnd[M:1] : rnd[M-1:0];
  assign ovf = fe >= $signed({3'b000, EMAX});
  assign rnd_res = ovf ? {sign_q, EMAX, M'(0)} : {sign_q, fe[EXP_W-1:0], frac};

  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    result_d = result_q;
    dbz_d = dbz_q;
    sign_d = sign_q;
    exp_d = exp_q;
    rem_d = rem_q;
    div_d = div_q;
    q_d = q_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (in_valid && in_ready_q) begin
        a_d = a;
        b_d = b;
        state_d = UNPACK;
      end
      UNPACK: begin
        sign_d = sa ^ sb;
        if (special) begin
          result_d = spec_res;
          dbz_d = spec_dbz;
          state_d = DONE;
        end else begin
          exp_d = xe - EW'(lt);
          rem_d = lt ? {ma, 1'b0} : {1'b0, ma};
          div_d = mb;
          q_d = '0;
          cnt_d = 7'(M + 3);
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        rem_d = rs << 1;
        q_d = {q_q[M+1:0], ge};
        cnt_d = cnt_q - 7'd1;
        state_d = cnt_q == 7'd1 ? ROUND : DIVIDE;
      end
      ROUND: begin
        result_d = rnd_res;
        dbz_d = 1'b0;
        state_d = DONE;
      end
      DONE: state_d = out_valid_q && out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    // Specials reach DONE with out_valid low and raise it one edge later
    out_valid_d = state_q == ROUND || (state_q == DONE && !(out_valid_q && out_ready));
    in_ready_d = state_d == IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      in_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      result_q <= '0;
      dbz_q <= 1'b0;
      sign_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      exp_q <= '0;
      rem_q <= '0;
      div_q <= '0;
      q_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q <= result_d;
      dbz_q <= dbz_d;
      sign_q <= sign_d;
      a_q <= a_d;
      b_q <= b_d;
      exp_q <= exp_d;
      rem_q <= rem_d;
      div_q <= div_d;
      q_q <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign result = result_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_fp_div.sv
// tb_fp_div: scoreboard bench for fp_div (fp16 random + directed, one fp32 directed op)
module tb_fp_div;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, dbz;
  logic [15:0] a = '0, b = '0, result;

  logic iv32 = 1'b0, or32 = 1'b1;
  logic ir32, ov32, dbz32;
  logic [31:0] a32 = '0, b32 = '0, res32;

  fp_div #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .div_by_zero(dbz)
  );

  fp_div #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .out_valid(ov32), .out_ready(or32), .result(res32), .div_by_zero(dbz32)
  );

  typedef struct {
    logic [15:0] res;
    logic        dbz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int cyc = 0, n_vec = 0, n_bad = 0, bp_hold = -1, hold = 0;
  bit seen = 0, chk_ir = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] da [10] = '{16'h4200, 16'h3C00, 16'h3C00, 16'h0000, 16'h7C00,
                           16'hC000, 16'h7BFF, 16'h0003, 16'h0001, 16'h0200};
  logic [15:0] db [10] = '{16'h4000, 16'h4200, 16'h0000, 16'h0000, 16'h7C00,
                           16'h7C00, 16'h3800, 16'h4000, 16'h4000, 16'h3800};
  logic [15:0] dr [10] = '{16'h3E00, 16'h3555, 16'h7C00, 16'h7E00, 16'h7E00,
                           16'h8000, 16'h7C00, 16'h0002, 16'h0000, 16'h0400};
  logic        dz [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  int          dl [10] = '{15, 15, 2, 2, 2, 2, 15, 15, 15, 15};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real mag(input logic [15:0] x);
    int e, f;
    e = int'(x[14:10]);
    f = int'(x[9:0]);
    return e == 0 ? f * pow2(-24) : (f + 1024) * pow2(e - 25);
  endfunction

  // Reference: exact special-case rules, otherwise real quotient rounded to fp16 by RNE
  task automatic model(input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] r, output logic z, output int lat);
    logic s, xn, yn, xi, yi, xz, yz;
    real q, n, fl;
    int e, nr;
    longint bits;
    s = x[15] ^ y[15];
    xn = x[14:10] == 5'h1F && x[9:0] != 0;
    yn = y[14:10] == 5'h1F && y[9:0] != 0;
    xi = x[14:10] == 5'h1F && x[9:0] == 0;
    yi = y[14:10] == 5'h1F && y[9:0] == 0;
    xz = x[14:0] == 0;
    yz = y[14:0] == 0;
    z = 1'b0;
    lat = 2;
    if (xn || yn || (xi && yi) || (xz && yz)) r = 16'h7E00;
    else if (xi) r = {s, 15'h7C00};
    else if (yz) begin
      r = {s, 15'h7C00};
      z = 1'b1;
    end else if (yi || xz) r = {s, 15'h0000};
    else begin
      lat = 15;
      q = mag(x) / mag(y);
      e = -14;
      while (e < 20 && q >= pow2(e + 1)) e++;
      n = q / pow2(e - 10);
      fl = $floor(n);
      nr = $rtoi(fl);
      if (n - fl > 0.5 || (n - fl == 0.5 && nr % 2 == 1)) nr++;
      bits = longint'((e + 14) * 1024) + longint'(nr);
      r = bits >= 64'h7C00 ? {s, 15'h7C00} : {s, bits[14:0]};
    end
  endtask

  function automatic logic [15:0] rnd_op();
    logic s;
    logic [9:0] f;
    int k;
    s = 1'($urandom);
    f = 10'($urandom);
    k = $urandom_range(0, 9);
    if (k == 0) return {s, 15'h0000};
    if (k == 1) return {s, 15'h7C00};
    if (k == 2) return {s, 5'h1F, f[9:1], 1'b1};
    if (k <= 4) return {s, 5'h00, f[9:1], 1'b1};
    if (k == 5) return {s, ($urandom_range(0, 1) == 1) ? 5'(29 + $urandom_range(0, 1)) : 5'(1 + $urandom_range(0, 1)), f};
    return {s, 5'($urandom_range(1, 30)), f};
  endfunction

  task automatic issue(input logic [15:0] x, input logic [15:0] y, input bit push,
                       input logic [15:0] er, input logic ez, input int el);
    exp_t e;
    bit ok;
    @(negedge clk);
    a = x;
    b = y;
    in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (in_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    e.res = er;
    e.dbz = ez;
    e.lat = el;
    e.acc = cyc + 1;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && (sb.size() != 0 || seen); i++) @(negedge clk);
    check("drain", 64'(sb.size()) + 64'(seen), 64'd0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 0;
        chk_ir = 0;
        out_ready = 1'b0;
      end else begin
        if (chk_ir) begin
          check("in_ready_after_hs", 64'(in_ready), 64'd1);
          check("out_valid_cleared", 64'(out_valid), 64'd0);
          chk_ir = 0;
        end
        if (out_valid) begin
          if (!seen) begin
            if (sb.size() == 0) check("unexpected_out", 64'(out_valid), 64'd0);
            else begin
              cur = sb.pop_front();
              check("latency", 64'(cyc - cur.acc), 64'(cur.lat));
              check("result", 64'(result), 64'(cur.res));
              check("div_by_zero", 64'(dbz), 64'(cur.dbz));
            end
            seen = 1;
            hold = bp_hold >= 0 ? bp_hold : $urandom_range(0, 3);
          end else check("hold_result", 64'(result), 64'(cur.res));
          check("in_ready_busy", 64'(in_ready), 64'd0);
          out_ready = hold == 0;
          if (hold > 0) hold--;
          if (out_ready) begin
            seen = 0;
            chk_ir = 1;
          end
        end else out_ready = 1'($urandom);
      end
    end
  end

  initial begin
    logic [15:0] x, y, er;
    logic ez;
    int el, t0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_dbz", 64'(dbz), 64'd0);
    check("rst_in_ready32", 64'(ir32), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 64'(in_ready), 64'd1);

    for (int i = 0; i < 10; i++) issue(da[i], db[i], 1, dr[i], dz[i], dl[i]);
    drain();

    for (int i = 0; i < 150; i++) begin
      x = rnd_op();
      y = rnd_op();
      model(x, y, er, ez, el);
      issue(x, y, 1, er, ez, el);
    end
    drain();

    bp_hold = 5;
    issue(16'h4200, 16'h4000, 1, 16'h3E00, 1'b0, 15);
    drain();
    bp_hold = -1;

    issue(16'h4200, 16'h4000, 0, 16'h0000, 1'b0, 0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(16'h4200, 16'h4000, 1, 16'h3E00, 1'b0, 15);
    drain();

    @(negedge clk);
    a32 = 32'h3F800000;
    b32 = 32'h40400000;
    iv32 = 1'b1;
    for (int i = 0; i < 50 && !ir32; i++) @(negedge clk);
    t0 = cyc + 1;
    @(posedge clk);
    #1;
    iv32 = 1'b0;
    a32 = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ov32) break;
    end
    check("fp32_latency", 64'(cyc - t0), 64'd28);
    check("fp32_result", 64'(res32), 64'h3EAAAAAB);
    check("fp32_dbz", 64'(dbz32), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
